// File: rtl/cmd_parser_if.sv
// rtl/cmd_parser_if.sv - byte-in / command-out handshake bundle for cmd_parser
interface cmd_parser_if;
   logic        rx_ready;
   logic [7:0]  rx_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_payload;
   logic        err;
   logic [1:0]  err_code;
   logic        ovr;

   modport slave (
      input  rx_ready, rx_data, cmd_ready,
      output cmd_valid, cmd_op, cmd_payload, err, err_code, ovr
   );

   modport master (
      output rx_ready, rx_data, cmd_ready,
      input  cmd_valid, cmd_op, cmd_payload, err, err_code, ovr
   );
endinterface

// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - UART byte-stream command frame decoder; CMD_PARSER_CHECKSUM_EN adds trailing XOR byte
module cmd_parser #(
   parameter int TIMEOUT_CYCLES = 640
) (
   input  logic        clk,
   input  logic        rst_n,
   cmd_parser_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES);

`ifdef CMD_PARSER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, HOLD} state_t;
   logic [7:0] csum_q, csum_d;
`else
   typedef enum logic [1:0] {IDLE, PAYLOAD, HOLD} state_t;
`endif

   state_t         state, state_d;
   logic [2:0]     op_q, op_d;
   logic [31:0]    pay_q, pay_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [CW-1:0]  tmo_q, tmo_d;
   logic           err_q, err_d;
   logic [1:0]     code_q, code_d;
   logic           ovr_q, ovr_d;
   logic           last_byte;
   state_t         frame_end;

`ifdef CMD_PARSER_CHECKSUM_EN
   assign frame_end = CHECK;
`else
   assign frame_end = HOLD;
`endif

   assign last_byte = (cnt_q == ((op_q == 3'd3) ? 2'd1 : 2'd3));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= '0;
         pay_q  <= '0;
         cnt_q  <= '0;
         tmo_q  <= '0;
         err_q  <= 1'b0;
         code_q <= '0;
         ovr_q  <= 1'b0;
`ifdef CMD_PARSER_CHECKSUM_EN
         csum_q <= '0;
`endif
      end else begin
         state  <= state_d;
         op_q   <= op_d;
         pay_q  <= pay_d;
         cnt_q  <= cnt_d;
         tmo_q  <= tmo_d;
         err_q  <= err_d;
         code_q <= code_d;
         ovr_q  <= ovr_d;
`ifdef CMD_PARSER_CHECKSUM_EN
         csum_q <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state;
      op_d    = op_q;
      pay_d   = pay_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      err_d   = 1'b0;
      code_d  = 2'b00;
      ovr_d   = 1'b0;
`ifdef CMD_PARSER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state)
         IDLE: begin
            if (bus.rx_ready) begin
               if (bus.rx_data >= 8'd1 && bus.rx_data <= 8'd4) begin
                  op_d  = bus.rx_data[2:0];
                  pay_d = '0;
                  cnt_d = '0;
                  tmo_d = '0;
`ifdef CMD_PARSER_CHECKSUM_EN
                  csum_d = bus.rx_data;
`endif
                  state_d = (bus.rx_data <= 8'd2) ? frame_end : PAYLOAD;
               end else begin
                  err_d  = 1'b1;
                  code_d = 2'b01;
               end
            end
         end
         PAYLOAD: begin
            if (bus.rx_ready) begin
               pay_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
               cnt_d = cnt_q + 2'd1;
               tmo_d = '0;
`ifdef CMD_PARSER_CHECKSUM_EN
               csum_d = csum_q ^ bus.rx_data;
`endif
               if (last_byte)
                  state_d = frame_end;
            end else if (tmo_q == TMO_MAX) begin
               // a byte landing on the expiry cycle wins over the timeout
               err_d   = 1'b1;
               code_d  = 2'b10;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
`ifdef CMD_PARSER_CHECKSUM_EN
         CHECK: begin
            if (bus.rx_ready) begin
               if (bus.rx_data == csum_q) begin
                  state_d = HOLD;
               end else begin
                  err_d   = 1'b1;
                  code_d  = 2'b11;
                  state_d = IDLE;
               end
            end else if (tmo_q == TMO_MAX) begin
               err_d   = 1'b1;
               code_d  = 2'b10;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
`endif
         HOLD: begin
            if (bus.rx_ready)
               ovr_d = 1'b1;
            if (bus.cmd_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cmd_valid   = (state == HOLD);
   assign bus.cmd_op      = (state == HOLD) ? op_q : 3'd0;
   assign bus.cmd_payload = (state == HOLD) ? pay_q : 32'd0;
   assign bus.err         = err_q;
   assign bus.err_code    = code_q;
   assign bus.ovr         = ovr_q;
endmodule
